// File: rtl/alu_arbiter_if.sv
// ----------------------------------------------------------------------------
// alu_arbiter_if: request/response bundle for the two-port ALU arbiter. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface alu_arbiter_if;
  logic [1:0] req_valid;
  logic [1:0] req_ready;
  logic [3:0] req_a0;
  logic [3:0] req_b0;
  logic [3:0] req_a1;
  logic [3:0] req_b1;
  logic [2:0] req_sel0;
  logic [2:0] req_sel1;
  logic [1:0] rsp_valid;
  logic [1:0] rsp_ready;
  logic [3:0] rsp_result0;
  logic [3:0] rsp_result1;
  logic [2:0] rsp_flags0;
  logic [2:0] rsp_flags1;

  modport master (
    output req_valid, req_a0, req_b0, req_a1, req_b1, req_sel0, req_sel1, rsp_ready,
    input  req_ready, rsp_valid, rsp_result0, rsp_result1, rsp_flags0, rsp_flags1
  );

  modport slave (
    input  req_valid, req_a0, req_b0, req_a1, req_b1, req_sel0, req_sel1, rsp_ready,
    output req_ready, rsp_valid, rsp_result0, rsp_result1, rsp_flags0, rsp_flags1
  );
endinterface

`default_nettype wire

// File: rtl/alu_arbiter.sv
// ----------------------------------------------------------------------------
// alu_arbiter: round-robin sharing of one 4-bit ALU between two ports. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module alu (
  input  logic [3:0] i_a,
  input  logic [3:0] i_b,
  input  logic [2:0] i_sel,
  output logic [3:0] o_result,
  output logic [2:0] o_flags
);
  logic [4:0] w_sum;
  logic [4:0] w_diff;

  // Subtraction is A + ~B + 1, so carry means "no borrow".
  assign w_sum  = {1'b0, i_a} + {1'b0, i_b};
  assign w_diff = {1'b0, i_a} + {1'b0, ~i_b} + 5'd1;

  always_comb begin
    o_result = 4'h0;
    o_flags  = 3'b000;
    case (i_sel)
      3'b000: begin
        o_result = w_sum[3:0];
        o_flags  = {(i_a[3] == i_b[3]) && (w_sum[3] != i_a[3]), w_sum[4], w_sum[3:0] == 4'h0};
      end
      3'b001: begin
        o_result = w_diff[3:0];
        o_flags  = {(i_a[3] != i_b[3]) && (w_diff[3] != i_a[3]), w_diff[4], w_diff[3:0] == 4'h0};
      end
      3'b010:  o_result = ~i_a;
      3'b011:  o_result = i_a & i_b;
      3'b100:  o_result = i_a | i_b;
      3'b101:  o_result = i_a ^ i_b;
      3'b110:  o_result = {3'b000, i_a < i_b};
      default: o_result = {3'b000, i_a == i_b};
    endcase
  end
endmodule

module alu_arbiter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  alu_arbiter_if.slave     bus,
  output logic [CNT_W-1:0] ops_done
);
  logic             r_prio;
  logic [1:0]       r_rsp_valid;
  logic [3:0]       r_result0;
  logic [3:0]       r_result1;
  logic [2:0]       r_flags0;
  logic [2:0]       r_flags1;
  logic [CNT_W-1:0] r_ops_done;

  logic [1:0] w_elig;
  logic [1:0] w_grant;
  logic [3:0] w_a;
  logic [3:0] w_b;
  logic [2:0] w_sel;
  logic [3:0] w_res;
  logic [2:0] w_flags;

  // A full buffer is still eligible when it is being drained this cycle.
  assign w_elig = bus.req_valid & (~r_rsp_valid | bus.rsp_ready);

  always_comb begin
    w_grant = 2'b00;
    if (!rst) begin
      if (&w_elig) w_grant = r_prio ? 2'b10 : 2'b01;
      else         w_grant = w_elig;
    end
  end

  assign w_a   = w_grant[1] ? bus.req_a1   : bus.req_a0;
  assign w_b   = w_grant[1] ? bus.req_b1   : bus.req_b0;
  assign w_sel = w_grant[1] ? bus.req_sel1 : bus.req_sel0;

  alu u_alu (
    .i_a      (w_a),
    .i_b      (w_b),
    .i_sel    (w_sel),
    .o_result (w_res),
    .o_flags  (w_flags)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_prio      <= 1'b0;
      r_rsp_valid <= 2'b00;
      r_result0   <= 4'h0;
      r_result1   <= 4'h0;
      r_flags0    <= 3'b000;
      r_flags1    <= 3'b000;
      r_ops_done  <= '0;
    end else begin
      if (w_grant[0]) begin
        r_result0      <= w_res;
        r_flags0       <= w_flags;
        r_rsp_valid[0] <= 1'b1;
      end else if (bus.rsp_ready[0]) begin
        r_rsp_valid[0] <= 1'b0;
      end

      if (w_grant[1]) begin
        r_result1      <= w_res;
        r_flags1       <= w_flags;
        r_rsp_valid[1] <= 1'b1;
      end else if (bus.rsp_ready[1]) begin
        r_rsp_valid[1] <= 1'b0;
      end

      // Winner i hands priority to the other port, i.e. prio <= ~i == grant[0].
      if (|w_grant) begin
        r_prio     <= w_grant[0];
        r_ops_done <= r_ops_done + CNT_W'(1);
      end
    end
  end

  assign bus.req_ready   = w_grant;
  assign bus.rsp_valid   = r_rsp_valid;
  assign bus.rsp_result0 = r_result0;
  assign bus.rsp_result1 = r_result1;
  assign bus.rsp_flags0  = r_flags0;
  assign bus.rsp_flags1  = r_flags1;
  assign ops_done        = r_ops_done;
endmodule

`default_nettype wire

// File: tb/tb_alu_arbiter.sv
// ----------------------------------------------------------------------------
// tb_alu_arbiter: directed self-checking bench for alu_arbiter. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_alu_arbiter;
  logic       clk;
  logic       rst;
  logic [7:0] ops_done;
  int         n_checks;
  int         n_errors;

  alu_arbiter_if bus ();

  alu_arbiter #(.CNT_W(8)) u_dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .ops_done (ops_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge; inputs change and outputs are sampled here.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1;
    bus.req_valid = 2'b11;
    bus.rsp_ready = 2'b00;
    bus.req_a0 = 4'h0; bus.req_b0 = 4'h0; bus.req_sel0 = 3'd0;
    bus.req_a1 = 4'h0; bus.req_b1 = 4'h0; bus.req_sel1 = 3'd0;

    // Reset state
    cyc();
    chk("rst_no_grant", bus.req_ready, 2'b00);
    cyc();
    rst = 1'b0;
    bus.req_valid = 2'b00;
    chk("rst_rsp_valid", bus.rsp_valid, 2'b00);
    chk("rst_ops_done", ops_done, 8'd0);
    chk("rst_result0", bus.rsp_result0, 4'h0);
    chk("rst_flags1", bus.rsp_flags1, 3'b000);

    // Port 0 add 7+1 -> 8 with signed overflow
    bus.req_a0 = 4'h7; bus.req_b0 = 4'h1; bus.req_sel0 = 3'd0;
    bus.req_valid = 2'b01; bus.rsp_ready = 2'b01;
    settle();
    chk("add_req_ready", bus.req_ready, 2'b01);
    cyc();
    bus.req_valid = 2'b00;
    chk("add_rsp_valid", bus.rsp_valid, 2'b01);
    chk("add_result", bus.rsp_result0, 4'h8);
    chk("add_flags", bus.rsp_flags0, 3'b100);
    chk("add_ops_done", ops_done, 8'd1);
    cyc();
    chk("add_drained", bus.rsp_valid, 2'b00);

    // Fresh reset so the alternating run starts from port 0
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    bus.req_a0 = 4'h5; bus.req_b0 = 4'h3; bus.req_sel0 = 3'd1;
    bus.req_a1 = 4'hA; bus.req_b1 = 4'hF; bus.req_sel1 = 3'd5;
    bus.req_valid = 2'b11; bus.rsp_ready = 2'b11;
    for (int k = 0; k < 4; k++) begin
      settle();
      chk($sformatf("alt_grant%0d", k), bus.req_ready, (k % 2 == 0) ? 2'b01 : 2'b10);
      cyc();
      if (k % 2 == 0) begin
        chk("alt_valid0", bus.rsp_valid[0], 1'b1);
        chk("sub_result", bus.rsp_result0, 4'h2);
        chk("sub_ovf_zero", {bus.rsp_flags0[2], bus.rsp_flags0[0]}, 2'b00);
      end else begin
        chk("alt_valid1", bus.rsp_valid[1], 1'b1);
        chk("xor_result", bus.rsp_result1, 4'h5);
        chk("xor_flags", bus.rsp_flags1, 3'b000);
      end
    end
    chk("alt_ops_done", ops_done, 8'd4);
    bus.req_valid = 2'b00;
    cyc();
    chk("alt_drained", bus.rsp_valid, 2'b00);

    // Port 1 slt 3<9, then back-pressure while port 0 keeps issuing
    bus.req_a1 = 4'h3; bus.req_b1 = 4'h9; bus.req_sel1 = 3'd6;
    bus.req_valid = 2'b10; bus.rsp_ready = 2'b01;
    settle();
    chk("slt_grant", bus.req_ready, 2'b10);
    cyc();
    chk("slt_valid", bus.rsp_valid[1], 1'b1);
    chk("slt_result", bus.rsp_result1, 4'h1);
    bus.req_a1 = 4'hC; bus.req_b1 = 4'hC; bus.req_sel1 = 3'd7;
    bus.req_a0 = 4'h2; bus.req_b0 = 4'h3; bus.req_sel0 = 3'd0;
    bus.req_valid = 2'b11;
    for (int k = 0; k < 2; k++) begin
      settle();
      chk($sformatf("bp_grant%0d", k), bus.req_ready, 2'b01);
      cyc();
      chk("bp_hold_valid1", bus.rsp_valid[1], 1'b1);
      chk("bp_hold_result1", bus.rsp_result1, 4'h1);
      chk("bp_add_result0", bus.rsp_result0, 4'h5);
    end
    bus.rsp_ready = 2'b11;
    settle();
    chk("eq_grant", bus.req_ready, 2'b10);
    cyc();
    chk("eq_valid", bus.rsp_valid[1], 1'b1);
    chk("eq_result", bus.rsp_result1, 4'h1);
    chk("eq_ops_done", ops_done, 8'd8);
    bus.req_valid = 2'b00;
    cyc();
    chk("eq_drained", bus.rsp_valid, 2'b00);

    // Drain-and-refill on port 0
    bus.req_a0 = 4'hF; bus.req_b0 = 4'h1; bus.req_sel0 = 3'd3;
    bus.req_valid = 2'b01; bus.rsp_ready = 2'b00;
    cyc();
    chk("and_result", bus.rsp_result0, 4'h1);
    bus.req_a0 = 4'hF; bus.req_b0 = 4'h2; bus.req_sel0 = 3'd4;
    settle();
    chk("full_no_grant", bus.req_ready, 2'b00);
    bus.rsp_ready = 2'b01;
    settle();
    chk("refill_grant", bus.req_ready, 2'b01);
    cyc();
    chk("refill_valid", bus.rsp_valid, 2'b01);
    chk("refill_result", bus.rsp_result0, 4'hF);

    // Fill both buffers, leaving prio at 1, then reset mid-operation
    bus.req_a1 = 4'h1; bus.req_b1 = 4'h1; bus.req_sel1 = 3'd2;
    bus.req_valid = 2'b10; bus.rsp_ready = 2'b00;
    cyc();
    bus.req_valid = 2'b01; bus.rsp_ready = 2'b01;
    cyc();
    chk("pre_rst_valid", bus.rsp_valid, 2'b11);
    bus.req_valid = 2'b11; bus.rsp_ready = 2'b00;
    rst = 1'b1;
    settle();
    chk("mid_rst_no_grant", bus.req_ready, 2'b00);
    cyc();
    rst = 1'b0;
    chk("mid_rst_valid", bus.rsp_valid, 2'b00);
    chk("mid_rst_ops", ops_done, 8'd0);
    bus.rsp_ready = 2'b11;
    settle();
    chk("mid_rst_prio", bus.req_ready, 2'b01);

    // Counter wrap with CNT_W = 8
    bus.req_valid = 2'b01;
    for (int k = 0; k < 256; k++) begin
      cyc();
      if (k == 254) chk("wrap_255", ops_done, 8'd255);
    end
    chk("wrap_0", ops_done, 8'd0);
    cyc();
    chk("wrap_1", ops_done, 8'd1);
    bus.req_valid = 2'b00;
    cyc();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

`default_nettype wire
